// File: rtl/present_test_pkg.sv
// Shared definitions for the PRESENT-128 test sequencer.
// Contents:
//   state_e      - FSM state encoding (also driven onto the debug state port)
//   DEF_*        - default parameter values for the sequencer
//   TIMER_W      - width of the shared duration timer
package present_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_LOAD   = 3'd2,
    S_WAIT   = 3'd3,
    S_RECORD = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  localparam int STATE_W             = 3;
  localparam int DEF_TEST_CASE_SIZE  = 32;
  localparam int DEF_SETUP_CYCLES    = 2;
  localparam int DEF_LOAD_CYCLES     = 1;
  localparam int DEF_TIMEOUT_CYCLES  = 64;
  localparam int TIMER_W             = 16;

endpackage

// File: rtl/present_test_timer.sv
// Loadable down-counter shared by the SETUP, LOAD and WAIT durations.
// Ports:
//   clk_i      - clock, posedge
//   rst_i      - synchronous active-high reset (count -> 0)
//   load_i     - load load_val_i this cycle (takes priority over counting)
//   load_val_i - value loaded; a value of N-1 gives N cycles until expiry
//   expired_o  - count is zero (the current cycle is the last of the duration)
module present_test_timer
  import present_test_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer stays expired.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/present_test_sequencer.sv
// Walks the PRESENT-128 test harness through every stored test case:
// drives the case address, pulses load, waits for the harness pass
// indication (or a timeout) and tallies the results.
// Ports:
//   sig_mstr_clk       - master clock, posedge
//   sig_in_rst         - synchronous active-high reset
//   sig_in_start       - single-cycle run request (ignored while busy)
//   sig_in_abort       - stop the run; results hold their partial values
//   sig_in_valid       - harness pass indication
//   vec_out_sel_addr   - test case address to the harness
//   sig_out_load       - registered load strobe, high only in LOAD
//   sig_out_busy       - run in progress (SETUP..FINISH)
//   sig_out_done       - sticky run-complete flag
//   vec_out_pass_cnt   - passed case count
//   vec_out_fail_cnt   - failed case count
//   vec_out_first_fail - lowest failing case index (0 when none)
//   sig_out_any_fail   - at least one failure recorded
//   vec_out_fail_map   - bit i set when case i failed
//   vec_out_dbg_state  - current FSM state (state_e encoding)
//
// Handshake: sig_in_valid has no ready partner; it is sampled only in WAIT,
// on each WAIT cycle, and a single high sample completes the case as a pass.
// Outside WAIT it is ignored, since done/valid from the previous case may
// still be asserted while the next case's address settles.
module present_test_sequencer
  import present_test_pkg::*;
#(
  parameter int TEST_CASE_SIZE = DEF_TEST_CASE_SIZE,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int LOAD_CYCLES    = DEF_LOAD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              sig_mstr_clk,
  input  logic                              sig_in_rst,
  input  logic                              sig_in_start,
  input  logic                              sig_in_abort,
  input  logic                              sig_in_valid,
  output logic [$clog2(TEST_CASE_SIZE)-1:0] vec_out_sel_addr,
  output logic                              sig_out_load,
  output logic                              sig_out_busy,
  output logic                              sig_out_done,
  output logic [$clog2(TEST_CASE_SIZE):0]   vec_out_pass_cnt,
  output logic [$clog2(TEST_CASE_SIZE):0]   vec_out_fail_cnt,
  output logic [$clog2(TEST_CASE_SIZE)-1:0] vec_out_first_fail,
  output logic                              sig_out_any_fail,
  output logic [TEST_CASE_SIZE-1:0]         vec_out_fail_map,
  output logic [STATE_W-1:0]                vec_out_dbg_state
);

  localparam int ADDR_W = $clog2(TEST_CASE_SIZE);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEST_CASE_SIZE - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [CNT_W-1:0]          pass_q, pass_d;
  logic [CNT_W-1:0]          fail_q, fail_d;
  logic [ADDR_W-1:0]         first_q, first_d;
  logic                      any_q, any_d;
  logic [TEST_CASE_SIZE-1:0] map_q, map_d;
  logic                      done_q, done_d;
  logic                      load_q, load_d;
  logic                      case_pass_q, case_pass_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expired;

  present_test_timer #(.W(TIMER_W)) u_timer (
    .clk_i      (sig_mstr_clk),
    .rst_i      (sig_in_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // State register
  always_ff @(posedge sig_mstr_clk) begin
    if (sig_in_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats every other transition out of a busy state
  // and also suppresses a start in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (sig_in_start && !sig_in_abort) state_d = S_SETUP;
      S_SETUP:  if (sig_in_abort) state_d = S_IDLE;
                else if (tmr_expired) state_d = S_LOAD;
      S_LOAD:   if (sig_in_abort) state_d = S_IDLE;
                else if (tmr_expired) state_d = S_WAIT;
      S_WAIT:   if (sig_in_abort) state_d = S_IDLE;
                else if (sig_in_valid || tmr_expired) state_d = S_RECORD;
      S_RECORD: if (sig_in_abort) state_d = S_IDLE;
                else if (addr_q == LAST_ADDR) state_d = S_FINISH;
                else state_d = S_SETUP;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    sig_out_busy      = (state_q != S_IDLE);
    vec_out_dbg_state = state_q;
  end

  // The timer is reloaded on entry to each timed state. WAIT loads
  // TIMEOUT_CYCLES-1 so the wait count (TIMEOUT_CYCLES-1 minus remaining)
  // starts at 0, and expiry marks the last cycle valid can still pass.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        S_SETUP: begin tmr_load = 1'b1; tmr_val = TIMER_W'(SETUP_CYCLES - 1);   end
        S_LOAD:  begin tmr_load = 1'b1; tmr_val = TIMER_W'(LOAD_CYCLES - 1);    end
        S_WAIT:  begin tmr_load = 1'b1; tmr_val = TIMER_W'(TIMEOUT_CYCLES - 1); end
        default: ;
      endcase
    end
  end

  // Result and address datapath
  always_comb begin
    addr_d      = addr_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    first_d     = first_q;
    any_d       = any_q;
    map_d       = map_q;
    done_d      = done_q;
    case_pass_d = case_pass_q;
    load_d      = (state_d == S_LOAD);

    if (state_q == S_IDLE && sig_in_start && !sig_in_abort) begin
      addr_d  = '0;
      pass_d  = '0;
      fail_d  = '0;
      first_d = '0;
      any_d   = 1'b0;
      map_d   = '0;
      done_d  = 1'b0;
    end

    if (state_q == S_WAIT) begin
      case_pass_d = sig_in_valid;
    end

    if (state_q == S_RECORD && !sig_in_abort) begin
      if (case_pass_q) begin
        pass_d = pass_q + CNT_W'(1);
      end else begin
        fail_d         = fail_q + CNT_W'(1);
        map_d[addr_q]  = 1'b1;
        any_d          = 1'b1;
        if (!any_q) first_d = addr_q;
      end
      if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
    end

    if (state_d == S_FINISH) done_d = 1'b1;
  end

  always_ff @(posedge sig_mstr_clk) begin
    if (sig_in_rst) begin
      addr_q      <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      first_q     <= '0;
      any_q       <= 1'b0;
      map_q       <= '0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      case_pass_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      first_q     <= first_d;
      any_q       <= any_d;
      map_q       <= map_d;
      done_q      <= done_d;
      load_q      <= load_d;
      case_pass_q <= case_pass_d;
    end
  end

  assign vec_out_sel_addr   = addr_q;
  assign sig_out_load       = load_q;
  assign sig_out_done       = done_q;
  assign vec_out_pass_cnt   = pass_q;
  assign vec_out_fail_cnt   = fail_q;
  assign vec_out_first_fail = first_q;
  assign sig_out_any_fail   = any_q;
  assign vec_out_fail_map   = map_q;

endmodule

// File: tb/tb_present_test_sequencer.sv
module tb_present_test_sequencer;
  import present_test_pkg::*;

  localparam int N       = 32;
  localparam int SETUP   = 2;
  localparam int LOADC   = 1;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sig_in_rst, sig_in_start, sig_in_abort, sig_in_valid;
  logic [4:0]  vec_out_sel_addr, vec_out_first_fail;
  logic        sig_out_load, sig_out_busy, sig_out_done, sig_out_any_fail;
  logic [5:0]  vec_out_pass_cnt, vec_out_fail_cnt;
  logic [31:0] vec_out_fail_map;
  logic [2:0]  vec_out_dbg_state;

  present_test_sequencer #(
    .TEST_CASE_SIZE(N), .SETUP_CYCLES(SETUP), .LOAD_CYCLES(LOADC), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sig_mstr_clk       (clk),
    .sig_in_rst         (sig_in_rst),
    .sig_in_start       (sig_in_start),
    .sig_in_abort       (sig_in_abort),
    .sig_in_valid       (sig_in_valid),
    .vec_out_sel_addr   (vec_out_sel_addr),
    .sig_out_load       (sig_out_load),
    .sig_out_busy       (sig_out_busy),
    .sig_out_done       (sig_out_done),
    .vec_out_pass_cnt   (vec_out_pass_cnt),
    .vec_out_fail_cnt   (vec_out_fail_cnt),
    .vec_out_first_fail (vec_out_first_fail),
    .sig_out_any_fail   (sig_out_any_fail),
    .vec_out_fail_map   (vec_out_fail_map),
    .vec_out_dbg_state  (vec_out_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- harness model ----------------
  // delay[i]: WAIT count at which valid first rises for case i (NEVER = never).
  // stale[i]: valid level driven outside WAIT while case i is being set up/loaded.
  int delay[N];
  bit stale[N];
  int load_count, cur, k, cycle, last_load_cycle;
  logic load_prev;

  function automatic int exp_wait(input int i);
    return (delay[i] <= TIMEOUT - 1) ? delay[i] + 1 : TIMEOUT;
  endfunction

  function automatic int exp_spacing(input int i);
    return SETUP + LOADC + exp_wait(i) + 1;
  endfunction

  task automatic model_reset();
    load_count = 0; cur = 0; k = -1; cycle = 0; last_load_cycle = 0; load_prev = 1'b0;
  endtask

  task automatic harness_update();
    cycle++;
    if (sig_out_load && !load_prev) begin
      if (load_count == 0) chk("first_load_time", cycle, SETUP + 1);
      else chk($sformatf("case%0d_latency", load_count - 1), cycle - last_load_cycle,
               exp_spacing(load_count - 1));
      chk($sformatf("load_addr%0d", load_count), vec_out_sel_addr, load_count);
      cur = (load_count < N) ? load_count : N - 1;
      load_count++;
      last_load_cycle = cycle;
      k = -1;
    end else if (!sig_out_load && load_prev) begin
      k = 0;
    end else if (k >= 0) begin
      if (k >= delay[cur] || k >= TIMEOUT - 1) k = -1;
      else k++;
    end
    load_prev = sig_out_load;
    if (sig_out_load)   sig_in_valid = stale[cur];
    else if (k >= 0)    sig_in_valid = (k >= delay[cur]);
    else                sig_in_valid = (load_count < N) ? stale[load_count] : 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    harness_update();
  endtask

  task automatic run_full(input string tag, input int busy_case, input int e_pass,
                          input int e_fail, input int e_first, input logic [31:0] e_map);
    bit pulsed;
    int c;
    model_reset();
    pulsed = 1'b0;
    sig_in_start = 1'b1;
    step();
    sig_in_start = 1'b0;
    chk({tag, "_busy_at_start"}, sig_out_busy, 1);
    chk({tag, "_done_cleared"}, sig_out_done, 0);
    chk({tag, "_pass_cleared"}, vec_out_pass_cnt, 0);
    chk({tag, "_map_cleared"}, vec_out_fail_map, 0);
    c = 0;
    while (!sig_out_done && c < 6000) begin
      if (!pulsed && busy_case > 0 && load_count == busy_case &&
          cycle == last_load_cycle + exp_spacing(busy_case - 1) - 1) begin
        sig_in_start = 1'b1;
        pulsed = 1'b1;
      end
      step();
      sig_in_start = 1'b0;
      c++;
    end
    if (!sig_out_done) chk({tag, "_done_timeout"}, 0, 1);
    else chk({tag, "_done_latency"}, cycle - last_load_cycle, LOADC + exp_wait(N - 1) + 1);
    chk({tag, "_load_count"}, load_count, N);
    chk({tag, "_busy_in_finish"}, sig_out_busy, 1);
    chk({tag, "_pass_cnt"}, vec_out_pass_cnt, e_pass);
    chk({tag, "_fail_cnt"}, vec_out_fail_cnt, e_fail);
    chk({tag, "_first_fail"}, vec_out_first_fail, e_first);
    chk({tag, "_any_fail"}, sig_out_any_fail, (e_fail != 0));
    chk({tag, "_fail_map"}, vec_out_fail_map, e_map);
    step();
    chk({tag, "_idle_after"}, vec_out_dbg_state, S_IDLE);
    chk({tag, "_busy_after"}, sig_out_busy, 0);
    chk({tag, "_done_sticky"}, sig_out_done, 1);
    chk({tag, "_pass_held"}, vec_out_pass_cnt, e_pass);
  endtask

  task automatic fill(input int d);
    for (int i = 0; i < N; i++) begin
      delay[i] = d;
      stale[i] = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int base_d; int ca; int da; int cb; int db; int stale_case; int busy_case;
    int e_pass; int e_fail; int e_first; logic [31:0] e_map;
  } run_vec_t;

  run_vec_t tbl[4];

  initial begin
    int c, e_pass, e_fail, e_first;
    logic [31:0] e_map;

    tbl[0] = '{33, -1, 0,     -1, 0,     -1, -1, 32, 0, 0, 32'h0000_0000};
    tbl[1] = '{33,  5, NEVER, 17, NEVER, -1,  2, 30, 2, 5, 32'h0002_0020};
    tbl[2] = '{33,  7, 63,     8, 64,    -1, -1, 31, 1, 8, 32'h0000_0100};
    tbl[3] = '{33,  3, NEVER, -1, 0,      3,  1, 31, 1, 3, 32'h0000_0008};

    sig_in_rst = 1'b1; sig_in_start = 1'b0; sig_in_abort = 1'b0; sig_in_valid = 1'b0;
    fill(33);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", vec_out_dbg_state, S_IDLE);
    chk("rst_busy", sig_out_busy, 0);
    chk("rst_load", sig_out_load, 0);
    chk("rst_done", sig_out_done, 0);
    chk("rst_counts", {vec_out_pass_cnt, vec_out_fail_cnt, vec_out_first_fail}, 0);
    chk("rst_map", {sig_out_any_fail, vec_out_fail_map}, 0);
    sig_in_rst = 1'b0;
    step();

    // Table-driven full runs
    for (int t = 0; t < 4; t++) begin
      fill(tbl[t].base_d);
      if (tbl[t].ca >= 0) delay[tbl[t].ca] = tbl[t].da;
      if (tbl[t].cb >= 0) delay[tbl[t].cb] = tbl[t].db;
      if (tbl[t].stale_case >= 0) stale[tbl[t].stale_case] = 1'b1;
      run_full($sformatf("tbl%0d", t), tbl[t].busy_case, tbl[t].e_pass, tbl[t].e_fail,
               tbl[t].e_first, tbl[t].e_map);
    end

    // Abort during WAIT of case 10
    fill(33);
    model_reset();
    sig_in_start = 1'b1;
    step();
    sig_in_start = 1'b0;
    c = 0;
    while (!(load_count == 11 && k == 5) && c < 3000) begin
      step();
      c++;
    end
    chk("abort_reached_wait10", (load_count == 11 && k == 5), 1);
    sig_in_abort = 1'b1;
    step();
    sig_in_abort = 1'b0;
    chk("abort_state", vec_out_dbg_state, S_IDLE);
    chk("abort_busy", sig_out_busy, 0);
    chk("abort_load", sig_out_load, 0);
    chk("abort_done", sig_out_done, 0);
    chk("abort_pass_cnt", vec_out_pass_cnt, 10);
    chk("abort_fail_cnt", vec_out_fail_cnt, 0);
    // start together with abort in IDLE: stays idle, nothing cleared
    sig_in_start = 1'b1; sig_in_abort = 1'b1;
    step();
    sig_in_start = 1'b0; sig_in_abort = 1'b0;
    chk("start_abort_state", vec_out_dbg_state, S_IDLE);
    chk("start_abort_pass_held", vec_out_pass_cnt, 10);
    step();
    chk("start_abort_still_idle", sig_out_busy, 0);
    run_full("restart", -1, 32, 0, 0, 32'h0);

    // Reset during LOAD
    fill(33);
    model_reset();
    sig_in_start = 1'b1;
    step();
    sig_in_start = 1'b0;
    c = 0;
    while (!sig_out_load && c < 20) begin
      step();
      c++;
    end
    chk("rst_mid_reached_load", sig_out_load, 1);
    sig_in_rst = 1'b1;
    step();
    sig_in_rst = 1'b0;
    chk("rst_mid_state", vec_out_dbg_state, S_IDLE);
    chk("rst_mid_outputs", {sig_out_load, sig_out_busy, sig_out_done, sig_out_any_fail}, 0);
    chk("rst_mid_vectors", {vec_out_sel_addr, vec_out_pass_cnt, vec_out_fail_cnt,
                            vec_out_first_fail}, 0);
    chk("rst_mid_map", vec_out_fail_map, 0);
    step();

    // Randomized runs against the reference model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0:       delay[i] = NEVER;
          1:       delay[i] = 63;
          2:       delay[i] = 64;
          default: delay[i] = $urandom_range(0, 70);
        endcase
        stale[i] = 1'($urandom_range(0, 1));
      end
      e_pass = 0; e_fail = 0; e_first = 0; e_map = '0;
      for (int i = 0; i < N; i++) begin
        if (delay[i] < TIMEOUT) begin
          e_pass++;
        end else begin
          if (e_fail == 0) e_first = i;
          e_fail++;
          e_map[i] = 1'b1;
        end
      end
      run_full($sformatf("rnd%0d", r), int'($urandom_range(1, N - 1)), e_pass, e_fail,
               e_first, e_map);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/present_test_sequencer.md
Name: present_test_sequencer

Overview:
- Drives the PRESENT-128 hardware test harness through every stored test case: selects the address, pulses load, waits for the pass indication and tallies results.
- Sits between the board controls and the harness. It drives the harness address and load inputs and consumes the harness valid output.
- Turns the harness's per-case manual check into an automatic regression with summary outputs.

Parameters:
- TEST_CASE_SIZE, 32, number of stored test cases; also the address range 0..TEST_CASE_SIZE-1.
- SETUP_CYCLES, 2, cycles the address is held before load so the test-vector and benchmark RAM reads settle.
- LOAD_CYCLES, 1, cycles load is held high.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before a case is declared failed.

Ports:
- sig_mstr_clk  in  1  master clock; all logic on posedge.
- sig_in_rst  in  1  synchronous, active-high reset.
- sig_in_start  in  1  single-cycle start request.
- sig_in_abort  in  1  stops the run.
- sig_in_valid  in  1  harness pass indication (checksum ok, done, and match).
- vec_out_sel_addr  out  $clog2(TEST_CASE_SIZE)  test case address to the harness.
- sig_out_load  out  1  load strobe to the harness/DUT.
- sig_out_busy  out  1  high while a run is in progress.
- sig_out_done  out  1  high after a complete run; sticky until the next start or reset.
- vec_out_pass_cnt  out  $clog2(TEST_CASE_SIZE)+1  number of passed cases.
- vec_out_fail_cnt  out  $clog2(TEST_CASE_SIZE)+1  number of failed cases.
- vec_out_first_fail  out  $clog2(TEST_CASE_SIZE)  lowest failing index; 0 if there are no failures.
- sig_out_any_fail  out  1  at least one failure recorded.
- vec_out_fail_map  out  TEST_CASE_SIZE  bit i set means case i failed.

Behaviour:
- Reset: the synchronous sig_in_rst, sampled on posedge, forces all registers and outputs to zero and the state to IDLE.
  - This applies in every state, including mid-run.
- States: IDLE, SETUP, LOAD, WAIT, RECORD, FINISH.
- IDLE: load=0, busy=0.
  - A start moves to SETUP with addr=0.
  - On entering SETUP from a start, pass_cnt, fail_cnt, first_fail, any_fail, fail_map and done are all cleared.
- SETUP: addr is held and the cycle counter runs SETUP_CYCLES, then goes to LOAD.
- LOAD: load=1 for exactly LOAD_CYCLES cycles, then goes to WAIT.
  - load is registered and is never high outside LOAD.
- WAIT: sig_in_valid is sampled only in this state, and is ignored in SETUP and LOAD because stale done/valid may persist from the previous case.
  - The wait counter starts at 0 on the first WAIT cycle.
  - Valid=1 while counter<TIMEOUT_CYCLES: the case passes and the state goes to RECORD.
  - Counter reaches TIMEOUT_CYCLES without valid: the case fails and the state goes to RECORD.
- RECORD (1 cycle), on a pass: pass_cnt++.
- RECORD (1 cycle), on a fail:
  - fail_cnt++ and fail_map[addr]=1;
  - any_fail=1;
  - if this is the first failure, first_fail=addr.
- RECORD exit: if addr==TEST_CASE_SIZE-1, go to FINISH; otherwise addr++ and go to SETUP.
  - addr never wraps.
- FINISH: done=1 and the state goes to IDLE the next cycle. done and the counters stay held.
- Addressing: addr is stable from SETUP entry through RECORD.
- busy: high in SETUP through FINISH.
- Invariant: pass_cnt + fail_cnt equals the number of cases recorded.
- Per-case latency: SETUP_CYCLES + LOAD_CYCLES + (wait cycles + 1) + 1 for RECORD.
- Start while busy: ignored.
- Abort: takes effect in any busy state. On the next edge the state is IDLE with load=0, busy=0 and done unchanged (stays 0). Counters and map hold their partial values.
- Start and abort in the same IDLE cycle: abort wins and the state stays IDLE.
- Reset has priority over both.

Decomposition:
- Shared package present_test_pkg holds the state encoding localparams and default widths. TEST_CASE_SIZE stays a module parameter, as elsewhere in the harness.
- One natural sub-module, present_test_timer: a loadable down-counter with an expiry flag, shared by the SETUP, LOAD and WAIT durations. The FSM and result registers stay in the top.

Test Plan:
- All cases pass: a behavioural harness model asserts valid 33 cycles into WAIT for every case; start → load pulsed 32 times with addr 0..31 in order, then done=1, pass_cnt=32, fail_cnt=0, fail_map=0, any_fail=0.
- Selected failures: the model never asserts valid for cases 5 and 17 → fail_cnt=2, pass_cnt=30, first_fail=5, fail_map=0x00020020, any_fail=1. Each failed case spends exactly 64 WAIT cycles.
- Timeout boundary: valid first asserted at wait count 63 → pass. Valid first asserted at count 64 → fail.
- Stale valid: the model holds valid high through SETUP/LOAD of case 3 and then drops it during WAIT → case 3 fails. The run never increments pass_cnt from valid outside WAIT.
- Abort and restart: abort during WAIT of case 10 → the next cycle gives IDLE with load=0, busy=0, done=0, pass_cnt=10. A later start clears the counters and reruns from addr 0.
- Reset mid-run, and start while busy: sig_in_rst asserted during LOAD → the next edge gives all outputs 0 and IDLE. A start pulsed during SETUP of a run has no effect on addr or the counters.
